seq_divider32: RTL



---
 rtl/seq_divider32.sv | 106 ++++++++++
 1 files changed

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// then a single sign fix-up cycle writing HI (remainder) and LO (quotient).
module seq_divider32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int PW = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  typedef struct packed {
    logic             sgn;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_raw;
  } op_t;

  state_t           state;
  op_t              op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] dvs_mag;
  logic [PW-1:0]    diff;
  logic             trial_ok;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // One extra guard bit above the partial remainder makes the MSB of the
  // trial a clean sign bit even when the shifted value exceeds 2^WIDTH.
  always_comb begin
    diff     = {prem, qreg[WIDTH-1]} + ~{2'b00, dvs_mag} + PW'(1);
    trial_ok = ~diff[PW-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op          <= '0;
      cnt         <= '0;
      prem        <= '0;
      qreg        <= '0;
      dvs_mag     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op.sgn     <= is_signed;
            op.dvd_neg <= dividend[WIDTH-1];
            op.dvs_neg <= divisor[WIDTH-1];
            op.dvd_raw <= dividend;
            qreg       <= (is_signed && dividend[WIDTH-1]) ? neg(dividend) : dividend;
            dvs_mag    <= (is_signed && divisor[WIDTH-1])  ? neg(divisor)  : divisor;
            prem       <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          prem <= trial_ok ? diff[WIDTH:0] : {prem[WIDTH-1:0], qreg[WIDTH-1]};
          qreg <= {qreg[WIDTH-2:0], trial_ok};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (dvs_mag == '0) begin
            quotient    <= '1;
            remainder   <= op.dvd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= (op.sgn && (op.dvd_neg ^ op.dvs_neg)) ? neg(qreg) : qreg;
            remainder   <= (op.sgn && op.dvd_neg) ? neg(prem[WIDTH-1:0]) : prem[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
